// File: rtl/damage_pkg.sv
// Shared types and defaults for the damage arbiter and its round-robin picker.
package damage_pkg;

  localparam int unsigned N_LANES_DEF = 4;
  localparam int unsigned DMG_W_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_START = 4'b0010,
    S_WAIT  = 4'b0100,
    S_RESP  = 4'b1000
  } state_e;

  function automatic int unsigned lane_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned LANE_IDX_W = lane_idx_w(N_LANES_DEF);

endpackage

// File: rtl/damage_arbiter_rr_picker.sv
// Combinational round-robin winner selection, searching upward from last_grant+1.
module rr_picker
  import damage_pkg::*;
#(
  parameter int unsigned N_LANES = N_LANES_DEF,
  parameter int unsigned IDX_W   = lane_idx_w(N_LANES)
) (
  input  logic [N_LANES-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [N_LANES-1:0] winner,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int unsigned lane;
    logic [IDX_W-1:0] lane_idx;
    logic found;
    winner   = '0;
    idx      = '0;
    found    = 1'b0;
    lane     = 0;
    lane_idx = '0;
    for (int unsigned off = 1; off <= N_LANES; off++) begin
      lane     = (32'(last_grant) + off) % N_LANES;
      lane_idx = IDX_W'(lane);
      if (!found && req[lane_idx]) begin
        found            = 1'b1;
        winner[lane_idx] = 1'b1;
        idx              = lane_idx;
      end
    end
  end

endmodule

// File: rtl/damage_arbiter.sv
// Arbitrates battlefront lanes onto one shared damage calculator with a
// start/done/ack handshake and a bounded wait for calc_done.
module damage_arbiter
  import damage_pkg::*;
#(
  parameter int unsigned N_LANES = N_LANES_DEF,
  parameter int unsigned DMG_W   = DMG_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_LANES-1:0]         req,
  input  logic [N_LANES*DMG_W-1:0]   req_atk,
  input  logic [N_LANES*DMG_W-1:0]   req_def,
  output logic [N_LANES-1:0]         grant,
  output logic                       calc_start,
  output logic [DMG_W-1:0]           calc_atk,
  output logic [DMG_W-1:0]           calc_def,
  input  logic                       calc_done,
  input  logic [DMG_W-1:0]           calc_result,
  output logic                       calc_ack,
  output logic [N_LANES-1:0]         ack,
  output logic [DMG_W-1:0]           result,
  output logic                       timeout_err
);

  localparam int unsigned IDX_W = lane_idx_w(N_LANES);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N_LANES - 1);

  state_e               state_q, state_d;
  logic [N_LANES-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     win_idx_q, win_idx_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [DMG_W-1:0]     atk_q, atk_d;
  logic [DMG_W-1:0]     def_q, def_d;
  logic [DMG_W-1:0]     result_q, result_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic                 timed_out_q, timed_out_d;

  logic [N_LANES-1:0]   pick_onehot;
  logic [IDX_W-1:0]     pick_idx;
  logic [DMG_W-1:0]     pick_atk, pick_def;

  rr_picker #(
    .N_LANES (N_LANES),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant_q),
    .winner     (pick_onehot),
    .idx        (pick_idx)
  );

  always_comb begin
    pick_atk = '0;
    pick_def = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (pick_onehot[i]) begin
        pick_atk = req_atk[i*DMG_W +: DMG_W];
        pick_def = req_def[i*DMG_W +: DMG_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    win_idx_d    = win_idx_q;
    last_grant_d = last_grant_q;
    atk_d        = atk_q;
    def_d        = def_q;
    result_d     = result_q;
    timer_d      = timer_q;
    timed_out_d  = timed_out_q;
    case (state_q)
      S_IDLE: begin
        if (enable && (req != '0)) begin
          state_d     = S_START;
          grant_d     = pick_onehot;
          win_idx_d   = pick_idx;
          atk_d       = pick_atk;
          def_d       = pick_def;
          timer_d     = '0;
          timed_out_d = 1'b0;
        end
      end
      S_START: begin
        // timer holds 0 during START, then tracks cycles elapsed since calc_start
        timer_d = TMR_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (calc_done) begin
          result_d = calc_result;
          state_d  = S_RESP;
        end else if (timer_q >= TMR_LAST) begin
          result_d    = '0;
          timed_out_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        last_grant_d = win_idx_q;
        grant_d      = '0;
        timed_out_d  = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      win_idx_q    <= '0;
      last_grant_q <= LAST_LANE;
      atk_q        <= '0;
      def_q        <= '0;
      result_q     <= '0;
      timer_q      <= '0;
      timed_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      win_idx_q    <= win_idx_d;
      last_grant_q <= last_grant_d;
      atk_q        <= atk_d;
      def_q        <= def_d;
      result_q     <= result_d;
      timer_q      <= timer_d;
      timed_out_q  <= timed_out_d;
    end
  end

  assign grant       = grant_q;
  assign calc_start  = (state_q == S_START);
  assign calc_ack    = (state_q == S_RESP);
  assign ack         = (state_q == S_RESP) ? grant_q : '0;
  assign timeout_err = (state_q == S_RESP) && timed_out_q;
  assign calc_atk    = atk_q;
  assign calc_def    = def_q;
  assign result      = result_q;

endmodule

// File: doc/damage_arbiter.md
DAMAGE_ARBITER -- requirements
Module: damage_arbiter

Interface
REQ-001 Parameter N_LANES, default 4, number of requesting battlefront lanes.
REQ-002 Parameter DMG_W, default 8, width of attack, defence and result values.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles to wait for calc_done.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  game-step enable; new arbitration only while high.
REQ-007 req  input  N_LANES  per-lane level request, held by the lane until its ack.
REQ-008 req_atk  input  N_LANES*DMG_W  per-lane attack operand; lane i at bits [i*DMG_W +: DMG_W].
REQ-009 req_def  input  N_LANES*DMG_W  per-lane defence operand, same packing.
REQ-010 grant  output  N_LANES  one-hot owner of the calculator, zero when idle.
REQ-011 calc_start  output  1  one-cycle start pulse to the shared damage calculator.
REQ-012 calc_atk, calc_def  output  DMG_W each  latched operands of the granted lane.
REQ-013 calc_done  input  1  calculator completion level.
REQ-014 calc_result  input  DMG_W  calculator result, valid while calc_done is high.
REQ-015 calc_ack  output  1  one-cycle acknowledge releasing the calculator from its done state.
REQ-016 ack  output  N_LANES  one-cycle per-lane result-valid pulse.
REQ-017 result  output  DMG_W  result presented with ack; held until the next ack.
REQ-018 timeout_err  output  1  one-cycle pulse concurrent with ack on a timed-out transaction.

Function
REQ-019 The FSM SHALL have four one-hot states, IDLE, START, WAIT and RESP, with no other reachable state.
REQ-020 IDLE: if enable=1 and req!=0, the arbiter SHALL pick the winner round-robin starting at (last_grant+1) mod N_LANES, latch its operands, set grant, and go to START; otherwise it stays in IDLE.
REQ-021 START: calc_start=1 for exactly one cycle, timer cleared to 0; next state is WAIT.
REQ-022 WAIT: calc_done=1 SHALL latch calc_result into result and go to RESP; otherwise timer increments.
REQ-023 WAIT: when timer reaches TIMEOUT-1 without calc_done, the FSM SHALL go to RESP with result=0 and timeout_err asserted in RESP.
REQ-024 RESP: ack[winner]=1 and calc_ack=1 for one cycle; last_grant is updated to the winner; grant clears at exit; next state is IDLE.
REQ-025 Latency: req sampled in IDLE at edge k gives calc_start high in cycle k+1; calc_done sampled at edge m gives ack high in cycle m+1.
REQ-026 At most one calc_start SHALL be issued per ack; back-to-back transactions spend at least one IDLE cycle between them.
REQ-027 A granted lane dropping req mid-transaction SHALL NOT abort it; ack still pulses.
REQ-028 Requests arriving during START, WAIT or RESP SHALL wait for the next IDLE arbitration.
REQ-029 enable falling mid-transaction SHALL NOT abort it; it only blocks the next grant.
REQ-030 calc_done asserted outside WAIT SHALL be ignored.
REQ-031 timer SHALL be ceil(log2(TIMEOUT+1)) bits wide and SHALL NOT wrap.
REQ-032 Round-robin SHALL wrap lane N_LANES-1 to lane 0; a lane that is still requesting gets no second grant while any other lane requests.

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE in any state, including mid-WAIT, with no ack or calc_ack issued for the aborted transaction.
REQ-034 Reset values: grant=0, ack=0, calc_start=0, calc_ack=0, timeout_err=0, calc_atk=0, calc_def=0, result=0, timer=0, last_grant=N_LANES-1, so lane 0 has first priority.

Structure
REQ-035 The package damage_pkg SHALL hold the state encodings, the N_LANES, DMG_W and TIMEOUT defaults, and the lane-index width.
REQ-036 The round-robin winner selection SHALL be one combinational sub-module, rr_picker (inputs req and last_grant; outputs one-hot winner and index).

Verification
REQ-037 Reset state: after reset, all outputs are 0; req=0001 and enable=1 give grant=0001 and calc_start one cycle later.
REQ-038 Round-robin: req=1111 held with the calculator answering done 3 cycles after start gives grants 0001, 0010, 0100, 1000, 0001 in order.
REQ-039 Data path: lane 2 with atk=0x40, def=0x10 gives calc_atk=0x40 and calc_def=0x10; calc_result=0x30 gives ack=0100, result=0x30 and calc_ack pulsed together.
REQ-040 Timeout: calc_done never asserted gives ack plus timeout_err exactly TIMEOUT cycles after calc_start, with result=0.
REQ-041 Reset mid-WAIT: reset in the 5th WAIT cycle gives IDLE, grant=0, and no ack; the next request gives a fresh calc_start.
REQ-042 Enable gating: enable=0 with req=0011 gives no grant; raising enable gives grant=0001 in the next START.
